branch_unit_pipe: RTL and testbench

Parametrised, pipelined branch resolution unit for the core's fetch/execute path. It accepts one branch descriptor per cycle over a valid/ready handshake and evaluates the condition against the Z flag. It returns a registered target/taken result one cycle later. It adds a circular return address stack (RAS), so BL pushes a link address and RET pops it, with overflow and underflow reporting.

---
 rtl/branch_unit_pipe_if.sv | 33 +++
 rtl/branch_unit_pipe.sv | 161 ++++++++++++++++
 tb/tb_branch_unit_pipe.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_unit_pipe_if.sv
// Handshake bundle between the branch descriptor producer and branch_unit_pipe.
// The unit attaches through the slave modport; the producer/consumer through master.
interface branch_unit_pipe_if #(
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 24
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_pc;
    logic [OFF_W-1:0]  in_offset;
    logic [2:0]        in_type;
    logic              in_z;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_target;
    logic              out_taken;
    logic              out_link_we;
    logic [ADDR_W-1:0] out_link;
    logic              out_ras_ovf;
    logic              out_ras_unf;

    modport slave (
        input  in_valid, in_pc, in_offset, in_type, in_z, out_ready,
        output in_ready, out_valid, out_target, out_taken, out_link_we,
               out_link, out_ras_ovf, out_ras_unf
    );

    modport master (
        output in_valid, in_pc, in_offset, in_type, in_z, out_ready,
        input  in_ready, out_valid, out_target, out_taken, out_link_we,
               out_link, out_ras_ovf, out_ras_unf
    );
endinterface

// File: rtl/branch_unit_pipe.sv
// Single-stage branch resolution unit with a circular return address stack.
// One descriptor per cycle in, registered target/taken result one cycle later.
module branch_unit_pipe #(
    parameter int ADDR_W    = 32,
    parameter int OFF_W     = 24,
    parameter int PIPE_OFS  = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    branch_unit_pipe_if.slave   bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [2:0] TYPE_B   = 3'd1;
    localparam logic [2:0] TYPE_BL  = 3'd2;
    localparam logic [2:0] TYPE_BEQ = 3'd3;
    localparam logic [2:0] TYPE_BNE = 3'd4;
    localparam logic [2:0] TYPE_RET = 3'd5;

    function automatic logic [ADDR_W-1:0] rel_target(input logic [ADDR_W-1:0] pc,
                                                    input logic [OFF_W-1:0]  off);
        logic signed [ADDR_W-1:0] off_ext;
        off_ext = ADDR_W'(signed'(off));
        return pc + ADDR_W'(PIPE_OFS) + (off_ext <<< 2);
    endfunction

    logic                 out_valid_q,   out_valid_d;
    logic [ADDR_W-1:0]    out_target_q,  out_target_d;
    logic                 out_taken_q,   out_taken_d;
    logic                 out_link_we_q, out_link_we_d;
    logic [ADDR_W-1:0]    out_link_q,    out_link_d;
    logic                 out_ras_ovf_q, out_ras_ovf_d;
    logic                 out_ras_unf_q, out_ras_unf_d;
    logic [PTR_W-1:0]     wp_q,          wp_d;
    logic [CNT_W-1:0]     cnt_q,         cnt_d;
    logic [ADDR_W-1:0]    ras_mem_q [RAS_DEPTH];

    logic                 in_ready;
    logic                 accept;
    logic                 ras_we;
    logic [ADDR_W-1:0]    rel;
    logic [ADDR_W-1:0]    seq;
    logic [ADDR_W-1:0]    ras_top;
    logic [PTR_W-1:0]     wp_dec;
    logic                 ras_empty;
    logic                 ras_full;

    assign in_ready  = !out_valid_q || bus.out_ready;
    assign accept    = bus.in_valid && in_ready;
    assign rel       = rel_target(bus.in_pc, bus.in_offset);
    assign seq       = bus.in_pc + ADDR_W'(4);
    assign wp_dec    = wp_q - PTR_W'(1);
    assign ras_top   = ras_mem_q[wp_dec];
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

    always_comb begin
        out_valid_d   = out_valid_q;
        out_target_d  = out_target_q;
        out_taken_d   = out_taken_q;
        out_link_we_d = out_link_we_q;
        out_link_d    = out_link_q;
        out_ras_ovf_d = out_ras_ovf_q;
        out_ras_unf_d = out_ras_unf_q;
        wp_d          = wp_q;
        cnt_d         = cnt_q;
        ras_we        = 1'b0;

        if (accept) begin
            out_valid_d   = 1'b1;
            out_target_d  = seq;
            out_taken_d   = 1'b0;
            out_link_we_d = 1'b0;
            out_link_d    = seq;
            out_ras_ovf_d = 1'b0;
            out_ras_unf_d = 1'b0;
            case (bus.in_type)
                TYPE_B: begin
                    out_target_d = rel;
                    out_taken_d  = 1'b1;
                end
                TYPE_BL: begin
                    out_target_d  = rel;
                    out_taken_d   = 1'b1;
                    out_link_we_d = 1'b1;
                    ras_we        = 1'b1;
                    wp_d          = wp_q + PTR_W'(1);
                    // A full stack keeps its count; the slot at wp is the oldest entry.
                    if (ras_full) begin
                        out_ras_ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                TYPE_BEQ: begin
                    out_taken_d  = bus.in_z;
                    out_target_d = bus.in_z ? rel : seq;
                end
                TYPE_BNE: begin
                    out_taken_d  = !bus.in_z;
                    out_target_d = !bus.in_z ? rel : seq;
                end
                TYPE_RET: begin
                    if (ras_empty) begin
                        out_ras_unf_d = 1'b1;
                    end else begin
                        out_target_d = ras_top;
                        out_taken_d  = 1'b1;
                        wp_d         = wp_dec;
                        cnt_d        = cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_target_q  <= '0;
            out_taken_q   <= 1'b0;
            out_link_we_q <= 1'b0;
            out_link_q    <= '0;
            out_ras_ovf_q <= 1'b0;
            out_ras_unf_q <= 1'b0;
            wp_q          <= '0;
            cnt_q         <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_target_q  <= out_target_d;
            out_taken_q   <= out_taken_d;
            out_link_we_q <= out_link_we_d;
            out_link_q    <= out_link_d;
            out_ras_ovf_q <= out_ras_ovf_d;
            out_ras_unf_q <= out_ras_unf_d;
            wp_q          <= wp_d;
            cnt_q         <= cnt_d;
        end
    end

    // Stack storage carries no reset; only pointer and count define its contents.
    always_ff @(posedge clk) begin
        if (ras_we && !rst) begin
            ras_mem_q[wp_q] <= seq;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_target  = out_target_q;
    assign bus.out_taken   = out_taken_q;
    assign bus.out_link_we = out_link_we_q;
    assign bus.out_link    = out_link_q;
    assign bus.out_ras_ovf = out_ras_ovf_q;
    assign bus.out_ras_unf = out_ras_unf_q;
endmodule

// File: tb/tb_branch_unit_pipe.sv
// Bench for branch_unit_pipe: vector table, directed RAS/backpressure sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_branch_unit_pipe;
    localparam int ADDR_W    = 32;
    localparam int OFF_W     = 24;
    localparam int PIPE_OFS  = 8;
    localparam int RAS_DEPTH = 4;

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_B    = 3'd1;
    localparam logic [2:0] T_BL   = 3'd2;
    localparam logic [2:0] T_BEQ  = 3'd3;
    localparam logic [2:0] T_BNE  = 3'd4;
    localparam logic [2:0] T_RET  = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_unit_pipe_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) bus ();

    branch_unit_pipe #(
        .ADDR_W(ADDR_W), .OFF_W(OFF_W), .PIPE_OFS(PIPE_OFS), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: expected output registers plus a bounded stack as a queue.
    logic        m_valid, m_taken, m_link_we, m_ovf, m_unf;
    logic [31:0] m_target, m_link;
    logic [31:0] m_ras[$];

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] pc;
        logic [23:0] off;
        logic        z;
        logic [31:0] tgt;
        logic        taken;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_taken = 0; m_link_we = 0; m_ovf = 0; m_unf = 0;
        m_target = 0; m_link = 0;
        m_ras.delete();
    endtask

    task automatic model_apply(input logic [31:0] pc, input logic [23:0] off,
                               input logic [2:0] typ, input logic z);
        int signed so;
        logic [31:0] rel, seq;
        so = int'(off);
        if (off[23]) so = so - (1 << 24);
        rel = pc + 32'(PIPE_OFS) + 32'(so * 4);
        seq = pc + 32'd4;
        m_valid = 1; m_taken = 0; m_link_we = 0; m_ovf = 0; m_unf = 0;
        m_target = seq; m_link = seq;
        case (typ)
            T_B:   begin m_target = rel; m_taken = 1; end
            T_BL: begin
                m_target = rel; m_taken = 1; m_link_we = 1;
                if (m_ras.size() == RAS_DEPTH) begin
                    m_ovf = 1;
                    void'(m_ras.pop_front());
                end
                m_ras.push_back(seq);
            end
            T_BEQ: begin m_taken = z;  m_target = z ? rel : seq; end
            T_BNE: begin m_taken = !z; m_target = !z ? rel : seq; end
            T_RET: begin
                if (m_ras.size() == 0) m_unf = 1;
                else begin m_target = m_ras.pop_back(); m_taken = 1; end
            end
            default: ;
        endcase
    endtask

    task automatic drive(input logic v, input logic [2:0] typ, input logic [31:0] pc,
                         input logic [23:0] off, input logic z, input logic ordy);
        bus.in_valid = v; bus.in_type = typ; bus.in_pc = pc;
        bus.in_offset = off; bus.in_z = z; bus.out_ready = ordy;
    endtask

    // One clock: check in_ready, advance model at the edge, check outputs on negedge.
    task automatic tick();
        logic exp_rdy, acc, ordy, rstv, z;
        logic [31:0] pc;
        logic [23:0] off;
        logic [2:0] typ;
        #1;
        exp_rdy = !m_valid || bus.out_ready;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        acc = bus.in_valid && exp_rdy;
        ordy = bus.out_ready; rstv = rst;
        pc = bus.in_pc; off = bus.in_offset; typ = bus.in_type; z = bus.in_z;
        @(posedge clk);
        if (rstv) model_reset();
        else if (acc) model_apply(pc, off, typ, z);
        else if (ordy) m_valid = 0;
        @(negedge clk);
        chk("out_valid",   32'(bus.out_valid),   32'(m_valid));
        chk("out_target",  bus.out_target,       m_target);
        chk("out_taken",   32'(bus.out_taken),   32'(m_taken));
        chk("out_link_we", 32'(bus.out_link_we), 32'(m_link_we));
        chk("out_ras_ovf", 32'(bus.out_ras_ovf), 32'(m_ovf));
        chk("out_ras_unf", 32'(bus.out_ras_unf), 32'(m_unf));
        if (m_link_we) chk("out_link", bus.out_link, m_link);
    endtask

    task automatic expect_out(input string n, input logic [31:0] tgt, input logic taken,
                              input logic lwe, input logic [31:0] link,
                              input logic ovf, input logic unf);
        chk({n, ".valid"},   32'(bus.out_valid),   32'd1);
        chk({n, ".target"},  bus.out_target,       tgt);
        chk({n, ".taken"},   32'(bus.out_taken),   32'(taken));
        chk({n, ".link_we"}, 32'(bus.out_link_we), 32'(lwe));
        if (lwe) chk({n, ".link"}, bus.out_link, link);
        chk({n, ".ovf"},     32'(bus.out_ras_ovf), 32'(ovf));
        chk({n, ".unf"},     32'(bus.out_ras_unf), 32'(unf));
    endtask

    initial begin
        vecs[0] = '{T_B,    32'h0000_1000, 24'h000004, 1'b0, 32'h0000_1018, 1'b1};
        vecs[1] = '{T_B,    32'h0000_1000, 24'hFFFFFE, 1'b0, 32'h0000_1000, 1'b1};
        vecs[2] = '{T_B,    32'hFFFF_FFFC, 24'h000000, 1'b0, 32'h0000_0004, 1'b1};
        vecs[3] = '{T_BEQ,  32'h0000_2000, 24'h000010, 1'b0, 32'h0000_2004, 1'b0};
        vecs[4] = '{T_BEQ,  32'h0000_2000, 24'h000010, 1'b1, 32'h0000_2048, 1'b1};
        vecs[5] = '{T_BNE,  32'h0000_2000, 24'h000010, 1'b1, 32'h0000_2004, 1'b0};
        vecs[6] = '{T_BNE,  32'h0000_2000, 24'h000010, 1'b0, 32'h0000_2048, 1'b1};
        vecs[7] = '{T_NONE, 32'h0000_3000, 24'h000010, 1'b1, 32'h0000_3004, 1'b0};
        vecs[8] = '{3'd6,   32'h0000_3000, 24'h000010, 1'b0, 32'h0000_3004, 1'b0};
        vecs[9] = '{3'd7,   32'h0000_3100, 24'h800000, 1'b1, 32'h0000_3104, 1'b0};

        model_reset();
        @(negedge clk);
        rst = 1;
        drive(1, T_B, 32'h1000, 24'h4, 0, 1);
        tick();
        tick();
        rst = 0;
        chk("reset.valid",  32'(bus.out_valid),  32'd0);
        chk("reset.target", bus.out_target,      32'd0);
        chk("reset.link",   bus.out_link,        32'd0);

        foreach (vecs[i]) begin
            drive(1, vecs[i].typ, vecs[i].pc, vecs[i].off, vecs[i].z, 1);
            tick();
            expect_out($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].taken, 0, 0, 0, 0);
        end

        drive(1, T_BL, 32'h100, 24'h0, 0, 1);  tick();
        expect_out("bl", 32'h108, 1, 1, 32'h104, 0, 0);
        drive(1, T_RET, 32'h800, 24'h0, 0, 1); tick();
        expect_out("ret1", 32'h104, 1, 0, 0, 0, 0);
        drive(1, T_RET, 32'h800, 24'h0, 0, 1); tick();
        expect_out("ret2", 32'h804, 0, 0, 0, 0, 1);

        for (int i = 1; i <= 5; i++) begin
            drive(1, T_BL, 32'(i * 16), 24'h0, 0, 1); tick();
            expect_out($sformatf("ovf_bl%0d", i), 32'(i * 16 + 8), 1, 1, 32'(i * 16 + 4), i == 5, 0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, T_RET, 32'h900, 24'h0, 0, 1); tick();
            if (i < 4) expect_out($sformatf("ovf_ret%0d", i), 32'(32'h54 - i * 16), 1, 0, 0, 0, 0);
            else       expect_out("ovf_ret_unf", 32'h904, 0, 0, 0, 0, 1);
        end

        drive(1, T_BL, 32'h200, 24'h0, 0, 1); tick();
        expect_out("bp_bl", 32'h208, 1, 1, 32'h204, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, T_BL, 32'h400, 24'h0, 0, 0); tick();
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            expect_out("bp_hold", 32'h208, 1, 1, 32'h204, 0, 0);
        end
        drive(0, T_BL, 32'h400, 24'h0, 0, 1); tick();
        chk("bp_drain", 32'(bus.out_valid), 32'd0);
        drive(1, T_RET, 32'h800, 24'h0, 0, 1); tick();
        expect_out("bp_ret", 32'h204, 1, 0, 0, 0, 0);

        drive(1, T_BL, 32'h500, 24'h0, 0, 1); tick();
        drive(1, T_B, 32'h600, 24'h0, 0, 0);
        rst = 1; tick(); rst = 0;
        chk("rst_pending.valid", 32'(bus.out_valid), 32'd0);
        drive(1, T_RET, 32'h700, 24'h0, 0, 1); tick();
        expect_out("rst_ret", 32'h704, 0, 0, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom,
                  24'($urandom), 1'($urandom), 1'($urandom_range(0, 9) < 7));
            tick();
        end
        drive(0, T_NONE, 0, 0, 0, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
